// File: rtl/fpu_apu_dispatcher_if.sv
// Signal bundle between the core APU port, the dispatcher and the FPU datapath.
// The master modport is the surrounding system (core + FPU); the slave modport is the dispatcher.
interface fpu_apu_dispatcher_if #(
  parameter int FLEN     = 32,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5
);
  // Handshakes: core side is req/gnt, and a request transfers in the cycle where apu_req_i
  // and apu_gnt_o are both high. FPU issue is valid/ready, and a request transfers in the cycle
  // where fpu_in_valid_o and fpu_in_ready_i are both high. Once valid is raised, it and its
  // payload stay stable until ready. Results return as one-cycle pulses:
  // fpu_out_valid_i from the FPU and apu_rvalid_o to the core.
  logic                  apu_req_i;
  logic                  apu_gnt_o;
  logic [NARGS*FLEN-1:0] apu_operands_i;
  logic [WOP-1:0]        apu_op_i;
  logic [NDSFLAGS-1:0]   apu_flags_i;
  logic                  apu_rvalid_o;
  logic [FLEN-1:0]       apu_result_o;
  logic [NUSFLAGS-1:0]   apu_flags_o;
  logic [2:0]            frm_i;
  logic                  flush_i;
  logic                  fflags_clr_i;
  logic [NUSFLAGS-1:0]   fflags_o;
  logic                  fpu_in_valid_o;
  logic                  fpu_in_ready_i;
  logic [NARGS*FLEN-1:0] fpu_operands_o;
  logic [WOP-1:0]        fpu_op_o;
  logic [2:0]            fpu_rm_o;
  logic                  fpu_out_valid_i;
  logic [FLEN-1:0]       fpu_result_i;
  logic [NUSFLAGS-1:0]   fpu_status_i;
  logic [1:0]            dbg_state;

  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i, frm_i, flush_i, fflags_clr_i,
           fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i,
    input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o, fflags_o,
           fpu_in_valid_o, fpu_operands_o, fpu_op_o, fpu_rm_o, dbg_state
  );

  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i, frm_i, flush_i, fflags_clr_i,
           fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i,
    output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o, fflags_o,
           fpu_in_valid_o, fpu_operands_o, fpu_op_o, fpu_rm_o, dbg_state
  );
endinterface

// File: rtl/fpu_apu_dispatcher.sv
// Single-outstanding bridge from the core APU port to the FPU: resolves rounding mode,
// issues with valid/ready, returns a one-cycle rvalid and keeps sticky fflags.
module fpu_apu_dispatcher #(
  parameter int FLEN     = 32,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5
) (
  input logic                 clk,
  input logic                 rst,
  fpu_apu_dispatcher_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [FLEN-1:0]     CANON_NAN = FLEN'(32'h7FC0_0000);
  localparam logic [NUSFLAGS-1:0] FLAG_NV   = NUSFLAGS'(5'b10000);

  state_t     state;
  logic       drop;
  logic       gnt;
  logic [2:0] rm_res;
  logic       rm_bad;
  logic       kill;
  logic       unused_flags;

  assign gnt           = bus.apu_req_i & (state == IDLE) & ~bus.flush_i;
  assign bus.apu_gnt_o = gnt;
  assign bus.dbg_state = state;
  assign rm_res        = (bus.apu_flags_i[2:0] == 3'b111) ? bus.frm_i : bus.apu_flags_i[2:0];
  // 101/110 are reserved encodings; a dynamic RM of 111 in frm_i is illegal as well
  assign rm_bad        = (rm_res >= 3'b101);
  // a flush arriving in the completion cycle discards that result too
  assign kill          = drop | bus.flush_i;
  assign unused_flags  = ^bus.apu_flags_i[NDSFLAGS-1:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      drop               <= 1'b0;
      bus.apu_rvalid_o   <= 1'b0;
      bus.apu_result_o   <= '0;
      bus.apu_flags_o    <= '0;
      bus.fflags_o       <= '0;
      bus.fpu_in_valid_o <= 1'b0;
      bus.fpu_operands_o <= '0;
      bus.fpu_op_o       <= '0;
      bus.fpu_rm_o       <= 3'b000;
    end else begin
      bus.apu_rvalid_o <= 1'b0;
      if (bus.fflags_clr_i) bus.fflags_o <= '0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (gnt) begin
            bus.fpu_operands_o <= bus.apu_operands_i;
            bus.fpu_op_o       <= bus.apu_op_i;
            if (rm_bad) begin
              bus.apu_result_o <= CANON_NAN;
              bus.apu_flags_o  <= FLAG_NV;
              bus.apu_rvalid_o <= 1'b1;
              state            <= RESP;
            end else begin
              bus.fpu_rm_o       <= rm_res;
              bus.fpu_in_valid_o <= 1'b1;
              state              <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.flush_i) drop <= 1'b1;
          if (bus.fpu_in_ready_i) begin
            bus.fpu_in_valid_o <= 1'b0;
            if (bus.fpu_out_valid_i) begin
              if (kill) begin
                drop  <= 1'b0;
                state <= IDLE;
              end else begin
                bus.apu_result_o <= bus.fpu_result_i;
                bus.apu_flags_o  <= bus.fpu_status_i;
                bus.apu_rvalid_o <= 1'b1;
                state            <= RESP;
              end
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.flush_i) drop <= 1'b1;
          if (bus.fpu_out_valid_i) begin
            if (kill) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              bus.apu_result_o <= bus.fpu_result_i;
              bus.apu_flags_o  <= bus.fpu_status_i;
              bus.apu_rvalid_o <= 1'b1;
              state            <= RESP;
            end
          end
        end
        RESP: begin
          // clear takes effect before the OR so a coincident clear keeps this op's flags
          bus.fflags_o <= (bus.fflags_clr_i ? '0 : bus.fflags_o) | bus.apu_flags_o;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_apu_dispatcher.sv
// Directed bench for fpu_apu_dispatcher: drivers issue requests and push expected responses,
// a monitor pops and compares on every apu_rvalid_o pulse.
module tb_fpu_apu_dispatcher;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fpu_apu_dispatcher_if bus ();

  fpu_apu_dispatcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;
  logic [4:0]  fl_before;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && bus.apu_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got result %h flags %b expected no response",
                 bus.apu_result_o, bus.apu_flags_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("response", {91'h0, bus.apu_result_o, bus.apu_flags_o}, {91'h0, mon_exp});
      end
    end
  end

  // Drive a request at the current negedge; returns at the next negedge with req dropped
  task automatic start_req(input logic [95:0] ops, input logic [5:0] op, input logic [2:0] rm,
                           input string tag);
    bus.apu_req_i      = 1'b1;
    bus.apu_operands_i = ops;
    bus.apu_op_i       = op;
    bus.apu_flags_i    = {12'h0, rm};
    #1;
    check({tag, "_gnt"}, 128'(bus.apu_gnt_o), 128'd1);
    @(negedge clk);
    bus.apu_req_i = 1'b0;
  endtask

  task automatic fpu_pulse(input logic [31:0] res, input logic [4:0] st);
    bus.fpu_out_valid_i = 1'b1;
    bus.fpu_result_i    = res;
    bus.fpu_status_i    = st;
    @(negedge clk);
    bus.fpu_out_valid_i = 1'b0;
  endtask

  // Full op through a zero-latency, always-ready FPU
  task automatic run_op(input logic [95:0] ops, input logic [5:0] op, input logic [2:0] rm,
                        input logic [2:0] exp_rm, input logic [31:0] res, input logic [4:0] st,
                        input string tag);
    exp_q.push_back({res, st});
    start_req(ops, op, rm, tag);
    check({tag, "_in_valid"}, 128'(bus.fpu_in_valid_o), 128'd1);
    check({tag, "_rm"}, 128'(bus.fpu_rm_o), 128'(exp_rm));
    check({tag, "_operands"}, 128'(bus.fpu_operands_o), 128'(ops));
    check({tag, "_op"}, 128'(bus.fpu_op_o), 128'(op));
    bus.fpu_in_ready_i = 1'b1;
    fpu_pulse(res, st);
    bus.fpu_in_ready_i = 1'b0;
    check({tag, "_rvalid_on"}, 128'(bus.apu_rvalid_o), 128'd1);
    @(negedge clk);
    check({tag, "_rvalid_off"}, 128'(bus.apu_rvalid_o), 128'd0);
    check({tag, "_idle"}, 128'(bus.dbg_state), 128'd0);
  endtask

  task automatic illegal_op(input logic [2:0] rm, input logic [2:0] frm, input string tag);
    bus.frm_i = frm;
    exp_q.push_back({32'h7FC0_0000, 5'b10000});
    start_req({32'h0, 32'h1, 32'h2}, 6'h02, rm, tag);
    check({tag, "_no_issue"}, 128'(bus.fpu_in_valid_o), 128'd0);
    check({tag, "_rvalid"}, 128'(bus.apu_rvalid_o), 128'd1);
    @(negedge clk);
    check({tag, "_fflags"}, 128'(bus.fflags_o), 128'(5'b10000));
  endtask

  task automatic clear_fflags();
    bus.fflags_clr_i = 1'b1;
    @(negedge clk);
    bus.fflags_clr_i = 1'b0;
    check("fflags_clear", 128'(bus.fflags_o), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    bus.apu_req_i       = 1'b0;
    bus.apu_operands_i  = '0;
    bus.apu_op_i        = '0;
    bus.apu_flags_i     = '0;
    bus.frm_i           = 3'b000;
    bus.flush_i         = 1'b0;
    bus.fflags_clr_i    = 1'b0;
    bus.fpu_in_ready_i  = 1'b0;
    bus.fpu_out_valid_i = 1'b0;
    bus.fpu_result_i    = '0;
    bus.fpu_status_i    = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", 128'(bus.dbg_state), 128'd0);
    check("rst_outputs", {bus.apu_rvalid_o, bus.fpu_in_valid_o, bus.apu_result_o,
          bus.apu_flags_o, bus.fflags_o, bus.fpu_rm_o, bus.fpu_op_o}, 128'd0);
    check("rst_operands", 128'(bus.fpu_operands_o), 128'd0);

    // zero-latency add, static RM
    run_op({32'h0, 32'h4000_0000, 32'h3F80_0000}, 6'h01, 3'b000, 3'b000,
           32'h4040_0000, 5'b00000, "add");
    check("add_fflags", 128'(bus.fflags_o), 128'd0);

    // dynamic RM resolved from frm_i
    bus.frm_i = 3'b011;
    run_op({32'h0, 32'h3F80_0000, 32'h3F80_0000}, 6'h03, 3'b111, 3'b011,
           32'h3F00_0000, 5'b00000, "dyn_rm");

    // illegal static RM and illegal dynamic frm_i bypass the FPU
    illegal_op(3'b101, 3'b000, "bad_rm");
    illegal_op(3'b111, 3'b110, "bad_frm");
    bus.frm_i = 3'b000;

    // FPU not ready for three cycles: issue must hold stable
    clear_fflags();
    exp_q.push_back({32'h40A0_0000, 5'b00001});
    start_req({32'h0, 32'h4000_0000, 32'h4020_0000}, 6'h05, 3'b001, "stall");
    for (int i = 0; i < 3; i++) begin
      check("stall_in_valid", 128'(bus.fpu_in_valid_o), 128'd1);
      check("stall_operands", 128'(bus.fpu_operands_o), {32'h0, 32'h0, 32'h4000_0000, 32'h4020_0000});
      check("stall_rm", 128'(bus.fpu_rm_o), 128'd1);
      @(negedge clk);
    end
    bus.fpu_in_ready_i = 1'b1;
    fpu_pulse(32'h40A0_0000, 5'b00001);
    bus.fpu_in_ready_i = 1'b0;
    check("stall_rvalid", 128'(bus.apu_rvalid_o), 128'd1);
    @(negedge clk);

    // flush while waiting: result discarded, flags untouched
    fl_before = bus.fflags_o;
    check("flush_pre_fflags", 128'(fl_before), 128'd1);
    start_req({32'h0, 32'h1, 32'h2}, 6'h06, 3'b010, "flush");
    bus.fpu_in_ready_i = 1'b1;
    @(negedge clk);
    bus.fpu_in_ready_i = 1'b0;
    check("flush_wait_state", 128'(bus.dbg_state), 128'd2);
    check("flush_wait_in_valid", 128'(bus.fpu_in_valid_o), 128'd0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    fpu_pulse(32'h1234_5678, 5'b00010);
    check("flush_idle", 128'(bus.dbg_state), 128'd0);
    check("flush_no_rvalid", 128'(bus.apu_rvalid_o), 128'd0);
    check("flush_fflags", 128'(bus.fflags_o), 128'(fl_before));
    bus.apu_req_i = 1'b1;
    bus.flush_i   = 1'b1;
    #1;
    check("flush_blocks_gnt", 128'(bus.apu_gnt_o), 128'd0);
    bus.flush_i = 1'b0;
    #1;
    check("gnt_after_flush", 128'(bus.apu_gnt_o), 128'd1);
    bus.apu_req_i = 1'b0;

    // sticky flag accumulation and coincident clear
    clear_fflags();
    run_op({32'h0, 32'h5, 32'h6}, 6'h01, 3'b000, 3'b000, 32'h1111_1111, 5'b00001, "acc1");
    check("acc1_fflags", 128'(bus.fflags_o), 128'(5'b00001));
    run_op({32'h0, 32'h7, 32'h8}, 6'h01, 3'b100, 3'b100, 32'h2222_2222, 5'b00100, "acc2");
    check("acc2_fflags", 128'(bus.fflags_o), 128'(5'b00101));
    exp_q.push_back({32'h3333_3333, 5'b00100});
    start_req({32'h0, 32'h9, 32'hA}, 6'h01, 3'b000, "clr_resp");
    bus.fpu_in_ready_i = 1'b1;
    fpu_pulse(32'h3333_3333, 5'b00100);
    bus.fpu_in_ready_i = 1'b0;
    bus.fflags_clr_i   = 1'b1;
    @(negedge clk);
    bus.fflags_clr_i = 1'b0;
    check("clr_resp_fflags", 128'(bus.fflags_o), 128'(5'b00100));

    // stray FPU result in IDLE is ignored
    fpu_pulse(32'hDEAD_BEEF, 5'b11111);
    check("stray_state", 128'(bus.dbg_state), 128'd0);
    check("stray_rvalid", 128'(bus.apu_rvalid_o), 128'd0);
    check("stray_fflags", 128'(bus.fflags_o), 128'(5'b00100));

    // reset while waiting, then a late FPU result
    start_req({32'h0, 32'hB, 32'hC}, 6'h07, 3'b000, "rst_mid");
    bus.fpu_in_ready_i = 1'b1;
    @(negedge clk);
    bus.fpu_in_ready_i = 1'b0;
    check("rst_mid_wait", 128'(bus.dbg_state), 128'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fpu_pulse(32'hCAFE_F00D, 5'b00001);
    check("rst_mid_state", 128'(bus.dbg_state), 128'd0);
    check("rst_mid_outputs", {bus.apu_rvalid_o, bus.fpu_in_valid_o, bus.apu_result_o,
          bus.apu_flags_o, bus.fflags_o, bus.fpu_rm_o, bus.fpu_op_o}, 128'd0);
    check("rst_mid_operands", 128'(bus.fpu_operands_o), 128'd0);

    repeat (2) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
